// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage RV32I pipeline.
// Tracks destination tags for EX/MEM/WB and drives the EX operand mux selects.
module fwd_hazard_ctrl #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [4:0]             id_rs1,
    input  logic [4:0]             id_rs2,
    input  logic                   id_use_rs1,
    input  logic                   id_use_rs2,
    input  logic [4:0]             id_rd,
    input  logic                   id_regwrite,
    input  logic                   id_memread,
    input  logic                   ex_flush,
    output logic [1:0]             fwd_a_sel,
    output logic [1:0]             fwd_b_sel,
    output logic                   stall,
    output logic                   idex_bubble,
    output logic                   ifid_flush,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    logic       ex_valid;
    logic [4:0] ex_rd;
    logic       ex_regwrite;
    logic       ex_memread;
    logic [4:0] ex_rs1;
    logic [4:0] ex_rs2;
    logic       ex_use_rs1;
    logic       ex_use_rs2;

    logic       mem_valid;
    logic [4:0] mem_rd;
    logic       mem_regwrite;

    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       wb_regwrite;

    logic       ex_load_new;
    logic       hit_rs1;
    logic       hit_rs2;

    // MEM is checked before WB so the youngest producer of a register wins.
    function automatic logic [1:0] pick_sel(
        input logic       consumer_valid,
        input logic       use_rs,
        input logic [4:0] rs,
        input logic       m_valid,
        input logic       m_regwrite,
        input logic [4:0] m_rd,
        input logic       w_valid,
        input logic       w_regwrite,
        input logic [4:0] w_rd
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (consumer_valid && use_rs && (rs != 5'd0)) begin
            if (m_valid && m_regwrite && (m_rd == rs)) begin
                sel = SEL_MEM;
            end else if (w_valid && w_regwrite && (w_rd == rs)) begin
                sel = SEL_WB;
            end
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a_sel = pick_sel(ex_valid, ex_use_rs1, ex_rs1, mem_valid, mem_regwrite, mem_rd,
                             wb_valid, wb_regwrite, wb_rd);
        fwd_b_sel = pick_sel(ex_valid, ex_use_rs2, ex_rs2, mem_valid, mem_regwrite, mem_rd,
                             wb_valid, wb_regwrite, wb_rd);
    end

    // A flush squashes the ID instruction, so it can never be the cause of a stall.
    always_comb begin
        hit_rs1     = id_use_rs1 && (id_rs1 == ex_rd);
        hit_rs2     = id_use_rs2 && (id_rs2 == ex_rd);
        stall       = id_valid && !ex_flush && ex_valid && ex_memread &&
                      (ex_rd != 5'd0) && (hit_rs1 || hit_rs2);
        idex_bubble = stall || ex_flush;
        ifid_flush  = ex_flush;
        ex_load_new = id_valid && !stall && !ex_flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_rd        <= 5'd0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            ex_rs1       <= 5'd0;
            ex_rs2       <= 5'd0;
            ex_use_rs1   <= 1'b0;
            ex_use_rs2   <= 1'b0;
            mem_valid    <= 1'b0;
            mem_rd       <= 5'd0;
            mem_regwrite <= 1'b0;
            wb_valid     <= 1'b0;
            wb_rd        <= 5'd0;
            wb_regwrite  <= 1'b0;
        end else begin
            if (ex_load_new) begin
                ex_valid    <= 1'b1;
                ex_rd       <= id_rd;
                ex_regwrite <= id_regwrite;
                ex_memread  <= id_memread;
                ex_rs1      <= id_rs1;
                ex_rs2      <= id_rs2;
                ex_use_rs1  <= id_use_rs1;
                ex_use_rs2  <= id_use_rs2;
            end else begin
                ex_valid    <= 1'b0;
                ex_rd       <= 5'd0;
                ex_regwrite <= 1'b0;
                ex_memread  <= 1'b0;
                ex_rs1      <= 5'd0;
                ex_rs2      <= 5'd0;
                ex_use_rs1  <= 1'b0;
                ex_use_rs2  <= 1'b0;
            end
            mem_valid    <= ex_valid;
            mem_rd       <= ex_rd;
            mem_regwrite <= ex_regwrite;
            wb_valid     <= mem_valid;
            wb_rd        <= mem_rd;
            wb_regwrite  <= mem_regwrite;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: the driver pushes hand-computed expectations per
// cycle, a negedge monitor pops and compares. A narrow-counter instance covers saturation.
module tb_fwd_hazard_ctrl;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic       use1;
        logic [4:0] rs2;
        logic       use2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } instr_t;

    localparam int EW = 31;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [4:0]  id_rd;
    logic        id_regwrite;
    logic        id_memread;
    logic        ex_flush;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic        stall;
    logic        idex_bubble;
    logic        ifid_flush;
    logic [15:0] stall_cnt;

    logic [1:0]  n_fwd_a_sel;
    logic [1:0]  n_fwd_b_sel;
    logic        n_stall;
    logic        n_idex_bubble;
    logic        n_ifid_flush;
    logic [7:0]  n_stall_cnt;

    logic [EW-1:0] exp_q[$];
    int            n_checks;
    int            n_errors;
    int            cyc_no;
    logic [15:0]   exp_cnt;

    fwd_hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_flush(ex_flush),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall),
        .idex_bubble(idex_bubble), .ifid_flush(ifid_flush), .stall_cnt(stall_cnt)
    );

    fwd_hazard_ctrl #(.STALL_CNT_W(8)) dut_narrow (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_flush(ex_flush),
        .fwd_a_sel(n_fwd_a_sel), .fwd_b_sel(n_fwd_b_sel), .stall(n_stall),
        .idex_bubble(n_idex_bubble), .ifid_flush(n_ifid_flush), .stall_cnt(n_stall_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // instruction builders
    function automatic instr_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        instr_t i;
        i = '{valid: 1'b1, rs1: rs1, use1: 1'b1, rs2: rs2, use2: 1'b1, rd: rd, rw: 1'b1, mr: 1'b0};
        return i;
    endfunction

    function automatic instr_t addi(input logic [4:0] rd, input logic [4:0] rs1);
        instr_t i;
        i = '{valid: 1'b1, rs1: rs1, use1: 1'b1, rs2: 5'd0, use2: 1'b0, rd: rd, rw: 1'b1, mr: 1'b0};
        return i;
    endfunction

    function automatic instr_t ld(input logic [4:0] rd, input logic [4:0] rs1);
        instr_t i;
        i = '{valid: 1'b1, rs1: rs1, use1: 1'b1, rs2: 5'd0, use2: 1'b0, rd: rd, rw: 1'b1, mr: 1'b1};
        return i;
    endfunction

    // register fields alias rd but are flagged unused, as an immediate-only op would be
    function automatic instr_t lui(input logic [4:0] rd);
        instr_t i;
        i = '{valid: 1'b1, rs1: rd, use1: 1'b0, rs2: rd, use2: 1'b0, rd: rd, rw: 1'b1, mr: 1'b0};
        return i;
    endfunction

    function automatic instr_t nop();
        instr_t i;
        i = '0;
        return i;
    endfunction

    // driver tasks
    task automatic drive(input instr_t i, input logic fl, input logic r);
        rst         = r;
        id_valid    = i.valid;
        id_rs1      = i.rs1;
        id_rs2      = i.rs2;
        id_use_rs1  = i.use1;
        id_use_rs2  = i.use2;
        id_rd       = i.rd;
        id_regwrite = i.rw;
        id_memread  = i.mr;
        ex_flush    = fl;
    endtask

    task automatic cyc(input instr_t i, input logic fl, input logic r, input logic [1:0] ea,
                       input logic [1:0] eb, input logic es, input logic ebub);
        logic [7:0] ecnt8;
        @(posedge clk);
        #1;
        drive(i, fl, r);
        ecnt8 = (exp_cnt > 16'd255) ? 8'hFF : exp_cnt[7:0];
        exp_q.push_back({ea, eb, es, ebub, fl, exp_cnt, ecnt8});
        if (r) exp_cnt = 16'd0;
        else if (es) exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic drain(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            drive(nop(), 1'b0, 1'b0);
        end
    endtask

    // scoreboard monitor
    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc_no, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [EW-1:0] e;
        cyc_no++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("fwd_a_sel",   int'(fwd_a_sel),   int'(e[30:29]));
            chk("fwd_b_sel",   int'(fwd_b_sel),   int'(e[28:27]));
            chk("stall",       int'(stall),       int'(e[26]));
            chk("idex_bubble", int'(idex_bubble), int'(e[25]));
            chk("ifid_flush",  int'(ifid_flush),  int'(e[24]));
            chk("stall_cnt",   int'(stall_cnt),   int'(e[23:8]));
            chk("stall_cnt8",  int'(n_stall_cnt), int'(e[7:0]));
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc_no   = 0;
        exp_cnt  = 16'd0;
        drive(nop(), 1'b0, 1'b1);
        repeat (2) @(posedge clk);

        // reset state
        cyc(nop(), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

        // add x5,x1,x2 ; sub x6,x5,x3
        cyc(alu(5, 1, 2), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        cyc(alu(6, 5, 3), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        cyc(nop(),        1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0);
        drain(3);

        // add x5 ; nop ; or x7,x4,x5
        cyc(alu(5, 1, 2), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        cyc(nop(),        1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        cyc(alu(7, 4, 5), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        cyc(nop(),        1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0);
        drain(3);

        // add x5 ; addi x5,x1 ; and x8,x5,x5  (MEM beats WB on both operands)
        cyc(alu(5, 1, 2), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        cyc(addi(5, 1),   1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        cyc(alu(8, 5, 5), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        cyc(nop(),        1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 1'b0);
        drain(3);

        // add x6 ; add x5 ; and x8,x5,x6  (10/01 mix)
        cyc(alu(6, 1, 2), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        cyc(alu(5, 1, 2), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        cyc(alu(8, 5, 6), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        cyc(nop(),        1'b0, 1'b0, 2'b10, 2'b01, 1'b0, 1'b0);
        drain(3);

        // lw x7,0(x1) ; add x9,x2,x7 -> one stall, then WB forward
        cyc(ld(7, 1),     1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        cyc(alu(9, 2, 7), 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1);
        cyc(alu(9, 2, 7), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        cyc(nop(),        1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0);
        drain(3);

        // lw x0 ; add x3,x0,x0 -> no stall, no forward
        cyc(ld(0, 1),     1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        cyc(alu(3, 0, 0), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        cyc(nop(),        1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        drain(3);

        // lw x4 ; lui x4 -> no stall
        cyc(ld(4, 1),     1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        cyc(lui(4),       1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        cyc(nop(),        1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        drain(3);

        // load-use coinciding with a flush: flush wins, consumer squashed
        cyc(ld(7, 1),     1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        cyc(alu(9, 2, 7), 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
        cyc(nop(),        1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        drain(3);

        // reset while a load sits in EX with its consumer in ID
        cyc(ld(7, 1),     1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        cyc(alu(9, 2, 7), 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1);
        cyc(alu(9, 2, 7), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        cyc(nop(),        1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        drain(3);

        // alternate load / dependent to pile up stalls past the 8-bit limit
        for (int k = 0; k < 300; k++) begin
            cyc(ld(7, 1),     1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
            cyc(alu(9, 2, 7), 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1);
        end
        cyc(nop(), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        cyc(nop(), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
